// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: {bo, DIFF} = A - B - bin, one bit per clock,
// LSB first, through a single full-subtractor cell with a registered borrow.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         bin,
  output logic [N-1:0] DIFF,
  output logic         bo,
  output logic         done,
  input  logic         ack
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [N-1:0]  sd_q, sd_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bo_q, bo_d;

  logic          d_bit;
  logic          br_cell;
  logic [N-1:0]  sd_shift;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_cell = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & br_q) | (sb_q[0] & br_q);

  generate
    if (N == 1) begin : g_sd_one
      assign sd_shift = d_bit;
    end else begin : g_sd_many
      assign sd_shift = {d_bit, sd_q[N-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sd_d  = sd_shift;
        br_d  = br_cell;
        cnt_d = cnt_q + 1'b1;
        // Last bit: publish the completed result straight from the cell.
        if (cnt_q == LAST) begin
          diff_d  = sd_shift;
          bo_d    = br_cell;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign DIFF  = diff_q;
  assign bo    = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at N=4 and N=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       start4 = 1'b0, bin4 = 1'b0, ack4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, bo4, done4;
  logic [3:0] diff4;

  logic       start8 = 1'b0, bin8 = 1'b0, ack8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, bo8, done8;
  logic [7:0] diff8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .ready(ready4),
    .A(a4), .B(b4), .bin(bin4), .DIFF(diff4), .bo(bo4),
    .done(done4), .ack(ack4)
  );

  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ready(ready8),
    .A(a8), .B(b8), .bin(bin8), .DIFF(diff8), .bo(bo8),
    .done(done8), .ack(ack8)
  );

  // Accept one N=4 operation and wait (bounded) for done; reports latency
  // and whether ready was ever seen high while the operation was in flight.
  task automatic start_and_wait4(input logic [3:0] a, input logic [3:0] b,
                                 input logic bi, output int lat,
                                 output logic ready_seen);
    @(posedge clk); #1;
    start4 = 1'b1; a4 = a; b4 = b; bin4 = bi;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    ready_seen = 1'b0;
    while (!done4 && lat < 50) begin
      if (ready4) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (ready4) ready_seen = 1'b1;
  endtask

  task automatic release_ack4();
    ack4 = 1'b1;
    @(posedge clk); #1;
    ack4 = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (ready4 !== 1'b1 || done4 !== 1'b0 || diff4 !== 4'h0 || bo4 !== 1'b0) begin
      failures++;
      $display("FAIL reset: ready=%b done=%b DIFF=%h bo=%b, expected ready=1 done=0 DIFF=0 bo=0",
               ready4, done4, diff4, bo4);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready4 !== 1'b1 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b done=%b, expected ready=1 done=0", ready4, done4);
    end
  endtask

  task automatic test_vector(input logic [3:0] a, input logic [3:0] b, input logic bi,
                             input logic [3:0] exp_d, input logic exp_bo, input string name);
    int lat;
    logic rs;
    start_and_wait4(a, b, bi, lat, rs);
    $display("op %s: A=%0d B=%0d bin=%0d -> DIFF=%h bo=%b latency=%0d", name, a, b, bi, diff4, bo4, lat);
    checks++;
    if (diff4 !== exp_d || bo4 !== exp_bo) begin
      failures++;
      $display("FAIL %s_result: DIFF=%h bo=%b, expected DIFF=%h bo=%b", name, diff4, bo4, exp_d, exp_bo);
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL %s_latency: got %0d, expected 4", name, lat);
    end
    checks++;
    if (rs !== 1'b0 || ready4 !== 1'b0) begin
      failures++;
      $display("FAIL %s_ready_busy: ready seen high=%b now=%b, expected 0", name, rs, ready4);
    end
    release_ack4();
    checks++;
    if (ready4 !== 1'b1 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL %s_ack: ready=%b done=%b, expected ready=1 done=0", name, ready4, done4);
    end
  endtask

  task automatic test_basic();
    test_vector(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, "basic");
  endtask

  task automatic test_borrow();
    test_vector(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "borrow_3m9");
    test_vector(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "borrow_bin");
    test_vector(4'd15, 4'd15, 1'b0, 4'h0, 1'b0, "equal");
  endtask

  task automatic test_done_hold();
    int lat;
    logic rs;
    int bad;
    start_and_wait4(4'd12, 4'd5, 1'b0, lat, rs);
    $display("op hold: A=12 B=5 bin=0 -> DIFF=%h bo=%b latency=%0d", diff4, bo4, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (done4 !== 1'b1 || diff4 !== 4'h7 || bo4 !== 1'b0) begin
        failures++;
        $display("FAIL done_hold[%0d]: done=%b DIFF=%h bo=%b, expected done=1 DIFF=7 bo=0",
                 i, done4, diff4, bo4);
      end
      @(posedge clk); #1;
    end
    release_ack4();
    // Result must persist through IDLE.
    @(posedge clk); #1;
    checks++;
    if (diff4 !== 4'h7 || bo4 !== 1'b0 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL hold_idle: DIFF=%h bo=%b done=%b, expected DIFF=7 bo=0 done=0", diff4, bo4, done4);
    end
  endtask

  task automatic test_ignored_start();
    int lat;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    // Pulse start in RUN with a different operand set.
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd0;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 2;
    while (!done4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op ignore: A=7 B=2 bin=0 -> DIFF=%h bo=%b latency=%0d", diff4, bo4, lat);
    checks++;
    if (diff4 !== 4'h5 || bo4 !== 1'b0 || lat !== 4) begin
      failures++;
      $display("FAIL start_in_run: DIFF=%h bo=%b lat=%0d, expected DIFF=5 bo=0 lat=4", diff4, bo4, lat);
    end
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd1;
    @(posedge clk); #1;
    start4 = 1'b0;
    checks++;
    if (done4 !== 1'b1 || ready4 !== 1'b0 || diff4 !== 4'h5) begin
      failures++;
      $display("FAIL start_in_done: done=%b ready=%b DIFF=%h, expected done=1 ready=0 DIFF=5",
               done4, ready4, diff4);
    end
    // ack and start together: return to IDLE without accepting.
    start4 = 1'b1; ack4 = 1'b1; a4 = 4'd12; b4 = 4'd1;
    @(posedge clk); #1;
    start4 = 1'b0; ack4 = 1'b0;
    checks++;
    if (ready4 !== 1'b1 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL ack_start_idle: ready=%b done=%b, expected ready=1 done=0", ready4, done4);
    end
    @(posedge clk); #1;
    checks++;
    if (ready4 !== 1'b1) begin
      failures++;
      $display("FAIL ack_start_no_accept: ready=%b, expected 1", ready4);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (done4 !== 1'b0 || diff4 !== 4'h5) begin
      failures++;
      $display("FAIL ack_start_no_result: done=%b DIFF=%h, expected done=0 DIFF=5", done4, diff4);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic rs;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd13; b4 = 4'd1; bin4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready4 !== 1'b1 || done4 !== 1'b0 || diff4 !== 4'h0 || bo4 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: ready=%b done=%b DIFF=%h bo=%b, expected ready=1 done=0 DIFF=0 bo=0",
               ready4, done4, diff4, bo4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_and_wait4(4'd5, 4'd2, 1'b0, lat, rs);
    $display("op after_reset: A=5 B=2 bin=0 -> DIFF=%h bo=%b latency=%0d", diff4, bo4, lat);
    checks++;
    if (diff4 !== 4'h3 || bo4 !== 1'b0 || lat !== 4) begin
      failures++;
      $display("FAIL after_reset: DIFF=%h bo=%b lat=%0d, expected DIFF=3 bo=0 lat=4", diff4, bo4, lat);
    end
    release_ack4();
  endtask

  task automatic test_exhaustive4();
    logic [4:0] exp;
    int lat, dly, bad;
    logic rs;
    bad = 0;
    for (int v = 0; v < 512; v++) begin
      exp = {1'b0, v[3:0]} - {1'b0, v[7:4]} - {4'b0, v[8]};
      start_and_wait4(v[3:0], v[7:4], v[8], lat, rs);
      checks++;
      if ({bo4, diff4} !== exp || lat !== 4) begin
        failures++;
        $display("FAIL exh4 A=%0d B=%0d bin=%0d: {bo,DIFF}=%h lat=%0d, expected %h lat=4",
                 v[3:0], v[7:4], v[8], {bo4, diff4}, lat, exp);
      end
      dly = $urandom_range(0, 5);
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
        if (done4 !== 1'b1) bad++;
      end
      release_ack4();
      checks++;
      if (done4 !== 1'b0 || bad != 0) begin
        failures++;
        $display("FAIL exh4_done_pulse: done=%b dropped=%0d, expected done=0 dropped=0", done4, bad);
        bad = 0;
      end
    end
    $display("op exhaustive N=4: 512 vectors");
  endtask

  task automatic test_random8();
    logic [8:0] exp;
    logic [7:0] a, b;
    logic bi;
    int lat, dly;
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      bi = 1'($urandom_range(0, 1));
      if (n == 0) begin a = 8'd0; b = 8'd255; bi = 1'b1; end
      if (n == 1) begin a = 8'd255; b = 8'd0; bi = 1'b0; end
      exp = {1'b0, a} - {1'b0, b} - {8'b0, bi};
      @(posedge clk); #1;
      start8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if ({bo8, diff8} !== exp || lat !== 8) begin
        failures++;
        $display("FAIL rnd8 A=%0d B=%0d bin=%0d: {bo,DIFF}=%h lat=%0d, expected %h lat=8",
                 a, b, bi, {bo8, diff8}, lat, exp);
      end
      dly = $urandom_range(0, 5);
      repeat (dly) @(posedge clk);
      #1;
      ack8 = 1'b1;
      @(posedge clk); #1;
      ack8 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (done8 !== 1'b0 || ready8 !== 1'b1) begin
        failures++;
        $display("FAIL rnd8_done_pulse: done=%b ready=%b, expected done=0 ready=1", done8, ready8);
      end
    end
    $display("op random N=8: 300 vectors");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_done_hold();
    test_ignored_start();
    test_reset_mid_run();
    test_exhaustive4();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
